// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search controller.
// Owns the search FSM state encoding and S-RAM port widths.
package rc4_pkg;

    localparam int          KEY_WIDTH_DEF = 24;
    localparam logic [23:0] KEY_LAST_DEF  = 24'h3FFFFF;
    localparam int          S_ADDR_W      = 8;
    localparam int          S_DATA_W      = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA,
        ST_PRGA,
        ST_DONE
    } state_t;

endpackage

// File: rtl/rc4_search_ctrl_s_port_mux.sv
// S-RAM port arbiter: forwards only the active phase's address,
// data and write enable; idle states drive a quiet port.
module s_port_mux
    import rc4_pkg::*;
(
    input  state_t              phase,
    input  logic [S_ADDR_W-1:0] init_address,
    input  logic [S_DATA_W-1:0] init_data,
    input  logic                init_wren,
    input  logic [S_ADDR_W-1:0] ksa_address,
    input  logic [S_DATA_W-1:0] ksa_data,
    input  logic                ksa_wren,
    input  logic [S_ADDR_W-1:0] prga_address,
    input  logic [S_DATA_W-1:0] prga_data,
    input  logic                prga_wren,
    output logic [S_ADDR_W-1:0] s_address,
    output logic [S_DATA_W-1:0] s_data,
    output logic                s_wren
);

    always_comb begin
        s_address = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        case (phase)
            ST_INIT: begin
                s_address = init_address;
                s_data    = init_data;
                s_wren    = init_wren;
            end
            ST_KSA: begin
                s_address = ksa_address;
                s_data    = ksa_data;
                s_wren    = ksa_wren;
            end
            ST_PRGA: begin
                s_address = prga_address;
                s_data    = prga_data;
                s_wren    = prga_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rc4_search_ctrl.sv
// RC4 brute-force key search sequencer: walks keys through the
// S-init, key-schedule and decrypt phases until a valid message.
module rc4_search_ctrl
    import rc4_pkg::*;
#(
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEF,
    parameter logic [KEY_WIDTH-1:0] KEY_LAST  = KEY_WIDTH'(KEY_LAST_DEF)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [KEY_WIDTH-1:0] key_start,
    output logic                 init_start,
    output logic                 ksa_start,
    output logic                 prga_start,
    input  logic                 init_finish,
    input  logic                 ksa_finish,
    input  logic                 prga_finish,
    input  logic                 prga_ok,
    input  logic [S_ADDR_W-1:0]  init_address,
    input  logic [S_ADDR_W-1:0]  ksa_address,
    input  logic [S_ADDR_W-1:0]  prga_address,
    input  logic [S_DATA_W-1:0]  init_data,
    input  logic [S_DATA_W-1:0]  ksa_data,
    input  logic [S_DATA_W-1:0]  prga_data,
    input  logic                 init_wren,
    input  logic                 ksa_wren,
    input  logic                 prga_wren,
    output logic [S_ADDR_W-1:0]  s_address,
    output logic [S_DATA_W-1:0]  s_data,
    output logic                 s_wren,
    output logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic                 done,
    output logic                 found
);

    state_t               state_q, state_d;
    logic                 first_q;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 found_q, found_d;

    // first_q marks the entry cycle of a state; finishes are ignored there
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            first_q <= 1'b0;
            key_q   <= '0;
            found_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= (state_d != state_q);
            key_q   <= key_d;
            found_q <= found_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        found_d    = found_q;
        init_start = 1'b0;
        ksa_start  = 1'b0;
        prga_start = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_INIT;
                    key_d   = key_start;
                    found_d = 1'b0;
                end
            end
            ST_INIT: begin
                init_start = first_q;
                if (!first_q && init_finish) state_d = ST_KSA;
            end
            ST_KSA: begin
                ksa_start = first_q;
                if (!first_q && ksa_finish) state_d = ST_PRGA;
            end
            ST_PRGA: begin
                prga_start = first_q;
                if (!first_q && prga_finish) begin
                    if (prga_ok) begin
                        state_d = ST_DONE;
                        found_d = 1'b1;
                    end else if (key_q >= KEY_LAST) begin
                        state_d = ST_DONE;
                        found_d = 1'b0;
                    end else begin
                        state_d = ST_INIT;
                        key_d   = key_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy  = (state_q == ST_INIT) || (state_q == ST_KSA) ||
                   (state_q == ST_PRGA);
    assign done  = (state_q == ST_DONE);
    assign key   = key_q;
    assign found = found_q;

    s_port_mux u_mux (
        .phase        (state_q),
        .init_address (init_address),
        .init_data    (init_data),
        .init_wren    (init_wren),
        .ksa_address  (ksa_address),
        .ksa_data     (ksa_data),
        .ksa_wren     (ksa_wren),
        .prga_address (prga_address),
        .prga_data    (prga_data),
        .prga_wren    (prga_wren),
        .s_address    (s_address),
        .s_data       (s_data),
        .s_wren       (s_wren)
    );

endmodule

// File: tb/tb_rc4_search_ctrl.sv
// Self-checking bench for rc4_search_ctrl: directed searches plus
// randomized traffic against a cycle-level behavioural model.
module tb_rc4_search_ctrl;

    localparam int          KW   = 24;
    localparam logic [23:0] LAST = 24'h000005;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] key_start;
    logic          init_start, ksa_start, prga_start;
    logic          init_finish, ksa_finish, prga_finish, prga_ok;
    logic [7:0]    init_address, ksa_address, prga_address;
    logic [7:0]    init_data, ksa_data, prga_data;
    logic          init_wren, ksa_wren, prga_wren;
    logic [7:0]    s_address, s_data;
    logic          s_wren;
    logic [KW-1:0] key;
    logic          busy, done, found;

    rc4_search_ctrl #(.KEY_WIDTH(KW), .KEY_LAST(LAST)) dut (
        .clock(clock), .reset(reset), .start(start), .key_start(key_start),
        .init_start(init_start), .ksa_start(ksa_start),
        .prga_start(prga_start), .init_finish(init_finish),
        .ksa_finish(ksa_finish), .prga_finish(prga_finish),
        .prga_ok(prga_ok), .init_address(init_address),
        .ksa_address(ksa_address), .prga_address(prga_address),
        .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren),
        .key(key), .busy(busy), .done(done), .found(found)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endfunction

    // Behavioural model: phase 0 idle, 1 init, 2 ksa, 3 prga, 4 done;
    // m_age counts cycles spent in the current phase.
    int          m_ph = 0;
    int          m_age = 0;
    logic [23:0] m_key = '0;
    bit          m_found = 1'b0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_ph <= 0; m_age <= 0; m_key <= '0; m_found <= 1'b0;
        end else begin
            m_age <= (m_age < 1000) ? m_age + 1 : m_age;
            if (m_ph == 0 || m_ph == 4) begin
                if (start) begin
                    m_ph <= 1; m_age <= 0;
                    m_key <= key_start; m_found <= 1'b0;
                end
            end else if (m_age > 0) begin
                if (m_ph == 1 && init_finish) begin
                    m_ph <= 2; m_age <= 0;
                end else if (m_ph == 2 && ksa_finish) begin
                    m_ph <= 3; m_age <= 0;
                end else if (m_ph == 3 && prga_finish) begin
                    m_age <= 0;
                    if (prga_ok) begin
                        m_ph <= 4; m_found <= 1'b1;
                    end else if (m_key >= LAST) begin
                        m_ph <= 4; m_found <= 1'b0;
                    end else begin
                        m_ph <= 1; m_key <= m_key + 24'd1;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [7:0] ea, ed;
        logic       ew;
        ea = 8'd0; ed = 8'd0; ew = 1'b0;
        if (m_ph == 1) begin ea = init_address; ed = init_data; ew = init_wren; end
        if (m_ph == 2) begin ea = ksa_address;  ed = ksa_data;  ew = ksa_wren;  end
        if (m_ph == 3) begin ea = prga_address; ed = prga_data; ew = prga_wren; end
        chk("busy", 32'(busy), 32'(m_ph >= 1 && m_ph <= 3));
        chk("done", 32'(done), 32'(m_ph == 4));
        chk("found", 32'(found), 32'(m_found));
        chk("key", 32'(key), 32'(m_key));
        chk("init_start", 32'(init_start), 32'(m_ph == 1 && m_age == 0));
        chk("ksa_start", 32'(ksa_start), 32'(m_ph == 2 && m_age == 0));
        chk("prga_start", 32'(prga_start), 32'(m_ph == 3 && m_age == 0));
        chk("s_address", 32'(s_address), 32'(ea));
        chk("s_data", 32'(s_data), 32'(ed));
        chk("s_wren", 32'(s_wren), 32'(ew));
    end

    // Phase responder: answers each start pulse with a finish 2 cycles later.
    int n_init, n_ksa, n_prga, ph, cd;

    task automatic resp_cycle(input logic [23:0] okk, input bit oken);
        init_finish = 0; ksa_finish = 0; prga_finish = 0; prga_ok = 0;
        if (init_start) begin ph = 1; cd = 2; n_init++; end
        else if (ksa_start) begin ph = 2; cd = 2; n_ksa++; end
        else if (prga_start) begin ph = 3; cd = 2; n_prga++; end
        else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                if (ph == 1) init_finish = 1;
                if (ph == 2) ksa_finish = 1;
                if (ph == 3) begin
                    prga_finish = 1;
                    prga_ok = oken && (key == okk);
                end
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic clear_in();
        start = 0; init_finish = 0; ksa_finish = 0; prga_finish = 0;
        prga_ok = 0; init_wren = 0; ksa_wren = 0; prga_wren = 0;
        init_address = 0; ksa_address = 0; prga_address = 0;
        init_data = 0; ksa_data = 0; prga_data = 0;
    endtask

    task automatic run_search(input logic [23:0] ks, input logic [23:0] okk,
                              input bit oken);
        bit ok;
        n_init = 0; n_ksa = 0; n_prga = 0; cd = 0; ph = 0; ok = 0;
        key_start = ks; start = 1;
        @(posedge clock); #1;
        start = 0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin ok = 1; break; end
            resp_cycle(okk, oken);
        end
        if (!ok) chk("search_timeout", 32'd0, 32'd1);
        clear_in();
        @(negedge clock);
    endtask

    initial begin
        reset = 1; key_start = '0;
        clear_in();
        @(negedge clock);
        chk("rst_key", 32'(key), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_found", 32'(found), 32'd0);
        chk("rst_s_wren", 32'(s_wren), 32'd0);
        @(posedge clock); #1;
        reset = 0;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        run_search(24'h000010, 24'h000010, 1'b1);
        chk("a_n_init", n_init, 1);
        chk("a_n_ksa", n_ksa, 1);
        chk("a_n_prga", n_prga, 1);
        chk("a_done", 32'(done), 32'd1);
        chk("a_found", 32'(found), 32'd1);
        chk("a_key", 32'(key), 32'h10);

        run_search(24'h000000, 24'h000003, 1'b1);
        chk("b_n_init", n_init, 4);
        chk("b_found", 32'(found), 32'd1);
        chk("b_key", 32'(key), 32'h3);

        run_search(24'h000004, 24'h000000, 1'b0);
        chk("c_n_init", n_init, 2);
        chk("c_done", 32'(done), 32'd1);
        chk("c_found", 32'(found), 32'd0);
        chk("c_key", 32'(key), 32'h5);

        // Stray finishes and foreign wren while in KSA
        @(posedge clock); #1;
        key_start = 0; start = 1; cd = 0;
        @(posedge clock); #1;
        start = 0;
        for (int i = 0; i < 50; i++) begin
            if (ksa_start) break;
            resp_cycle(24'h0, 1'b0);
        end
        chk("d_ksa_entered", 32'(ksa_start), 32'd1);
        clear_in();
        init_finish = 1; prga_finish = 1; init_wren = 1; ksa_wren = 0;
        init_address = 8'h11; ksa_address = 8'h22; ksa_data = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("d_busy", 32'(busy), 32'd1);
            chk("d_s_wren", 32'(s_wren), 32'd0);
            chk("d_s_address", 32'(s_address), 32'h22);
            chk("d_prga_start", 32'(prga_start), 32'd0);
            @(posedge clock); #1;
        end
        clear_in();
        ksa_finish = 1;
        @(posedge clock); #1;
        ksa_finish = 0;
        chk("e_prga_start", 32'(prga_start), 32'd1);

        // Reset mid-PRGA
        reset = 1;
        @(negedge clock);
        chk("e_busy", 32'(busy), 32'd0);
        chk("e_done", 32'(done), 32'd0);
        chk("e_key", 32'(key), 32'd0);
        chk("e_prga_start", 32'(prga_start), 32'd0);
        @(posedge clock); #1;
        reset = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("e_idle_busy", 32'(busy), 32'd0);
        chk("e_idle_init_start", 32'(init_start), 32'd0);
        run_search(24'h0000A0, 24'h0, 1'b0);
        chk("e_n_init", n_init, 1);
        chk("e_key_a0", 32'(key), 32'hA0);
        chk("e_found", 32'(found), 32'd0);

        // Held start in DONE restarts with found cleared
        run_search(24'h000002, 24'h000002, 1'b1);
        chk("f_found_before", 32'(found), 32'd1);
        @(posedge clock); #1;
        key_start = 24'h000001; start = 1;
        @(posedge clock); #1;
        chk("f_busy", 32'(busy), 32'd1);
        chk("f_found", 32'(found), 32'd0);
        chk("f_init_start", 32'(init_start), 32'd1);
        chk("f_key", 32'(key), 32'h1);
        start = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            start        = ($urandom_range(0, 7) == 0);
            key_start    = 24'($urandom_range(0, 8));
            init_finish  = ($urandom_range(0, 3) == 0);
            ksa_finish   = ($urandom_range(0, 3) == 0);
            prga_finish  = ($urandom_range(0, 3) == 0);
            prga_ok      = ($urandom_range(0, 2) == 0);
            init_address = 8'($urandom); ksa_address = 8'($urandom);
            prga_address = 8'($urandom);
            init_data    = 8'($urandom); ksa_data = 8'($urandom);
            prga_data    = 8'($urandom);
            init_wren    = 1'($urandom); ksa_wren = 1'($urandom);
            prga_wren    = 1'($urandom);
            @(posedge clock); #1;
        end
        reset = 0;
        clear_in();
        @(negedge clock);
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/rc4_search_ctrl.md
RC4_SEARCH_CTRL -- requirements
Module: rc4_search_ctrl

Interface
REQ-001 Parameter KEY_WIDTH, default 24, key register width.
REQ-002 Parameter KEY_LAST, default 24'h3FFFFF, highest key searched.
REQ-003 clock  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request a search; sampled only in IDLE or DONE.
REQ-006 key_start  in  KEY_WIDTH  first key tried; latched on start acceptance.
REQ-007 init_start / ksa_start / prga_start  out  1 each  one-cycle start pulse to S-init, key-schedule and decrypt FSMs.
REQ-008 init_finish / ksa_finish / prga_finish  in  1 each  one-cycle completion pulse from each phase FSM.
REQ-009 prga_ok  in  1  decrypted message valid; qualified only by prga_finish.
REQ-010 init_address, ksa_address, prga_address  in  8 each  per-phase S-RAM address.
REQ-011 init_data, ksa_data, prga_data  in  8 each  per-phase S-RAM write data.
REQ-012 init_wren, ksa_wren, prga_wren  in  1 each  per-phase S-RAM write enable.
REQ-013 s_address, s_data  out  8 each  and s_wren  out  1: arbitrated S-RAM port.
REQ-014 key  out  KEY_WIDTH  key currently under test / final key.
REQ-015 busy  out  1  high in INIT, KSA, PRGA.
REQ-016 done  out  1  high in DONE.
REQ-017 found  out  1  valid when done; 1 = prga_ok seen for current key.

Function
REQ-018 States: IDLE, INIT, KSA, PRGA, DONE; encoding owned by package.
REQ-019 IDLE or DONE, start=1 -> INIT next cycle; key<=key_start, found<=0.
REQ-020 Each phase start pulse is high exactly the first cycle in its state; never otherwise.
REQ-021 INIT, init_finish=1 (not first cycle) -> KSA.
REQ-022 KSA, ksa_finish=1 (not first cycle) -> PRGA.
REQ-023 PRGA, prga_finish=1 and prga_ok=1 -> DONE, found<=1, key held.
REQ-024 PRGA, prga_finish=1, prga_ok=0, key>=KEY_LAST -> DONE, found<=0, key held.
REQ-025 PRGA, prga_finish=1, prga_ok=0, key<KEY_LAST -> INIT, key<=key+1; no wrap past KEY_LAST.
REQ-026 key_start>KEY_LAST: exactly one attempt, then DONE per REQ-023/024.
REQ-027 Finish pulses from non-active phases, and on a phase's first cycle, are ignored.
REQ-028 prga_ok ignored unless prga_finish=1 in PRGA.
REQ-029 start ignored while busy; held start in DONE restarts a new search.
REQ-030 S-port mux combinational: INIT->init_*, KSA->ksa_*, PRGA->prga_*; IDLE/DONE -> s_address=0, s_data=0, s_wren=0.
REQ-031 Inactive phases' wren never reaches s_wren.
REQ-032 Start-to-init_start latency 1 cycle; finish-to-next-start latency 1 cycle.

Reset
REQ-033 reset=1 forces IDLE immediately, any state, including mid-phase.
REQ-034 Reset values: key=0, found=0, done=0, busy=0, all start pulses 0, s_wren=0.
REQ-035 After deassertion, no activity until start=1 sampled.

Structure
REQ-036 Package rc4_pkg holds state enum, KEY_WIDTH/KEY_LAST defaults and S-RAM width constants.
REQ-037 One sub-module s_port_mux: phase-select + three address/data/wren sets -> S-RAM port.
REQ-038 FSM, key counter and pulse generation in rc4_search_ctrl; no other sub-modules.

Verification
REQ-039 key_start=0x000010, prga_ok=1 on first prga_finish -> init/ksa/prga_start once each, done=1, found=1, key=0x000010.
REQ-040 key_start=0x000000, prga_ok=1 only at key 3 -> four INIT passes, done=1, found=1, key=0x000003.
REQ-041 KEY_LAST=0x000005, key_start=0x000004, prga_ok=0 always -> two attempts, done=1, found=0, key=0x000005.
REQ-042 In KSA, drive init_finish and prga_finish, init_wren=1 ksa_wren=0 -> state stays KSA, s_wren=0, s_address=ksa_address.
REQ-043 Assert reset during PRGA, then start with key_start=0x0000A0 -> immediate IDLE, outputs at reset values, next search begins at key 0x0000A0.
REQ-044 start held high across DONE -> new search restarts next cycle with found cleared.
